// File: rtl/spi_shift_engine_pkg.sv
// Shared types and defaults for the SPI shift engine slice.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } spi_state_e;

  localparam int unsigned SPI_DWIDTH  = 8;
  localparam int unsigned SPI_CLK_DIV = 2;

  // Counter width that stays legal for a modulus of 1.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_shift_engine_if.sv
// FIFO-side handshake between the shift engine (master) and the TX/RX FIFOs.
interface spi_shift_engine_if #(
  parameter int unsigned DWIDTH = spi_pkg::SPI_DWIDTH
) ();

  logic [DWIDTH-1:0] tx_data;
  logic              tx_empty;
  logic              tx_rd;
  logic [DWIDTH-1:0] rx_data;
  logic              rx_wr;
  logic              rx_full;
  logic              ovf_clr;
  logic              rx_ovf;

  modport master (
    input  tx_data, tx_empty, rx_full, ovf_clr,
    output tx_rd, rx_data, rx_wr, rx_ovf
  );

  modport slave (
    output tx_data, tx_empty, rx_full, ovf_clr,
    input  tx_rd, rx_data, rx_wr, rx_ovf
  );

endinterface

// File: rtl/spi_shift_engine_clk_gen.sv
// SCLK half-period divider: SCLK starts low while run is held and toggles every CLK_DIV cycles.
module spi_clk_gen
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = SPI_CLK_DIV
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_run,
  output logic o_rise,
  output logic o_fall,
  output logic o_sclk
);

  localparam int unsigned   CW   = cnt_width(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          r_sclk;
  logic          w_wrap;

  assign w_wrap = i_run && (r_cnt == LAST);
  assign o_rise = w_wrap && !r_sclk;
  assign o_fall = w_wrap && r_sclk;
  assign o_sclk = r_sclk;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt  <= '0;
      r_sclk <= 1'b0;
    end else if (!i_run) begin
      r_cnt  <= '0;
      r_sclk <= 1'b0;
    end else if (w_wrap) begin
      r_cnt  <= '0;
      r_sclk <= ~r_sclk;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/spi_shift_engine.sv
// SPI mode-0 master shift engine, MSB first, fed by a FWFT TX FIFO and draining into an RX FIFO.
module spi_shift_engine
  import spi_pkg::*;
#(
  parameter int unsigned DWIDTH  = SPI_DWIDTH,
  parameter int unsigned CLK_DIV = SPI_CLK_DIV
) (
  input  logic                      PCLK,
  input  logic                      PRESETn,
  input  logic                      enable,
  spi_shift_engine_if.master        bus,
  output logic                      busy,
  output logic                      SCLK,
  output logic                      MOSI,
  input  logic                      MISO,
  output logic                      SS_n
);

  localparam int unsigned   BW      = cnt_width(DWIDTH);
  localparam logic [BW-1:0] LASTBIT = BW'(DWIDTH - 1);

  spi_state_e        r_state, w_next;
  logic [DWIDTH-1:0] r_tx_sr;
  logic [DWIDTH-1:0] r_rx_sr;
  logic [DWIDTH-1:0] r_rx_data;
  logic [BW-1:0]     r_bitcnt;
  logic              r_ovf;
  logic              w_rise, w_fall, w_last;
  logic              w_tx_rd, w_rx_wr, w_ss_n, w_mosi, w_busy;

  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .i_clk   (PCLK),
    .i_rst_n (PRESETn),
    .i_run   (r_state == ST_SHIFT),
    .o_rise  (w_rise),
    .o_fall  (w_fall),
    .o_sclk  (SCLK)
  );

  assign w_last = w_fall && (r_bitcnt == LASTBIT);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_tx_rd = 1'b0;
    w_rx_wr = 1'b0;
    w_ss_n  = 1'b0;
    w_mosi  = 1'b0;
    w_busy  = 1'b1;
    unique case (r_state)
      ST_IDLE: begin
        w_ss_n = 1'b1;
        w_busy = 1'b0;
        if (enable && !bus.tx_empty) w_next = ST_LOAD;
      end
      ST_LOAD: begin
        w_tx_rd = !bus.tx_empty;
        w_next  = ST_SHIFT;
      end
      ST_SHIFT: begin
        w_mosi = r_tx_sr[DWIDTH-1];
        if (w_last) w_next = ST_DONE;
      end
      ST_DONE: begin
        w_rx_wr = !bus.rx_full;
        w_next  = (enable && !bus.tx_empty) ? ST_LOAD : ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // rx_data is captured on the edge entering DONE so it is already valid alongside rx_wr.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_tx_sr   <= '0;
      r_rx_sr   <= '0;
      r_rx_data <= '0;
      r_bitcnt  <= '0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          r_tx_sr  <= bus.tx_data;
          r_rx_sr  <= '0;
          r_bitcnt <= '0;
        end
        ST_SHIFT: begin
          if (w_rise) r_rx_sr <= {r_rx_sr[DWIDTH-2:0], MISO};
          if (w_fall) begin
            r_tx_sr  <= {r_tx_sr[DWIDTH-2:0], 1'b0};
            r_bitcnt <= r_bitcnt + BW'(1);
          end
          if (w_last) r_rx_data <= r_rx_sr;
        end
        default: ;
      endcase
    end
  end

  // A frame dropped on a full RX FIFO outranks a simultaneous clear.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn)                                r_ovf <= 1'b0;
    else if (r_state == ST_DONE && bus.rx_full)  r_ovf <= 1'b1;
    else if (bus.ovf_clr)                        r_ovf <= 1'b0;
  end

  assign bus.tx_rd   = w_tx_rd;
  assign bus.rx_wr   = w_rx_wr;
  assign bus.rx_data = r_rx_data;
  assign bus.rx_ovf  = r_ovf;
  assign SS_n        = w_ss_n;
  assign MOSI        = w_mosi;
  assign busy        = w_busy;

endmodule

// File: tb/tb_spi_shift_engine.sv
// Directed/randomized bench for spi_shift_engine with a FIFO and SPI slave model.
module tb_spi_shift_engine;

  localparam int unsigned DW = 8;

  logic PCLK = 1'b0;
  logic PRESETn, enable;
  logic busy, SCLK, MOSI, SS_n, MISO;
  logic busy1, SCLK1, MOSI1, SS1;
  logic busy3, SCLK3, MOSI3, SS3;

  spi_shift_engine_if #(.DWIDTH(DW)) bus  ();
  spi_shift_engine_if #(.DWIDTH(DW)) bus1 ();
  spi_shift_engine_if #(.DWIDTH(DW)) bus3 ();

  spi_shift_engine #(.DWIDTH(DW), .CLK_DIV(2)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .enable(enable), .bus(bus),
    .busy(busy), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO), .SS_n(SS_n)
  );

  spi_shift_engine #(.DWIDTH(DW), .CLK_DIV(1)) dut1 (
    .PCLK(PCLK), .PRESETn(PRESETn), .enable(enable), .bus(bus1),
    .busy(busy1), .SCLK(SCLK1), .MOSI(MOSI1), .MISO(MOSI1), .SS_n(SS1)
  );

  spi_shift_engine #(.DWIDTH(DW), .CLK_DIV(3)) dut3 (
    .PCLK(PCLK), .PRESETn(PRESETn), .enable(enable), .bus(bus3),
    .busy(busy3), .SCLK(SCLK3), .MOSI(MOSI3), .MISO(MOSI3), .SS_n(SS3)
  );

  always #5 PCLK = ~PCLK;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int          cyc   = 0;

  logic [7:0]  txq[$];
  logic [7:0]  slvq[$];
  logic [7:0]  rxq[$];
  logic [7:0]  slv_word = 8'h00;
  int unsigned slv_idx = 0;
  logic        p_txrd = 1'b0, p_sclk = 1'b0, p_ss = 1'b1;
  int unsigned n_txrd, n_rxwr, n_rise, n_fall, n_ss_rise, n_viol;
  int          txrd_cyc, rxwr_cyc;
  logic [31:0] mosi_bits;

  int          a_tlast[2], a_ivmin[2], a_ivmax[2];
  int unsigned a_ntog[2], a_nwr[2];
  logic [7:0]  a_rx[2];
  logic        a_psclk[2], a_ptxrd[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rx_at(input int i);
    return (rxq.size() > i) ? rxq[i] : 8'hxx;
  endfunction

  task automatic fifo_refresh();
    bus.tx_empty = (txq.size() == 0);
    bus.tx_data  = (txq.size() != 0) ? txq[0] : 8'h00;
  endtask

  task automatic push(input logic [7:0] w, input logic [7:0] s);
    txq.push_back(w);
    slvq.push_back(s);
    fifo_refresh();
  endtask

  task automatic reset_counters();
    n_txrd = 0; n_rxwr = 0; n_rise = 0; n_fall = 0; n_ss_rise = 0;
    txrd_cyc = -1000; rxwr_cyc = 0; mosi_bits = '0;
    rxq.delete();
  endtask

  task automatic aux_reset();
    for (int k = 0; k < 2; k++) begin
      a_tlast[k] = -1; a_ivmin[k] = 1000; a_ivmax[k] = 0;
      a_ntog[k] = 0; a_nwr[k] = 0; a_rx[k] = 8'h00;
    end
  endtask

  task automatic aux_track(input int k, input logic sc, input logic rd,
                           input logic wr, input logic [7:0] d);
    int iv;
    if (sc !== a_psclk[k]) begin
      if (a_tlast[k] >= 0) begin
        iv = cyc - a_tlast[k];
        if (iv < a_ivmin[k]) a_ivmin[k] = iv;
        if (iv > a_ivmax[k]) a_ivmax[k] = iv;
      end
      a_tlast[k] = cyc;
      a_ntog[k]++;
    end
    if (wr) begin a_nwr[k]++; a_rx[k] = d; end
    a_psclk[k] = sc;
    a_ptxrd[k] = rd;
  endtask

  // One PCLK cycle: FIFO pops land on the edge, the slave reacts to SCLK, outputs sampled 2 ns later.
  task automatic step();
    @(posedge PCLK);
    #1;
    cyc++;
    if (p_txrd && txq.size() != 0) void'(txq.pop_front());
    fifo_refresh();
    if (a_ptxrd[0]) bus1.tx_empty = 1'b1;
    if (a_ptxrd[1]) bus3.tx_empty = 1'b1;
    #1;
    if (bus.tx_rd) begin
      n_txrd++;
      txrd_cyc = cyc;
      if (bus.tx_empty) n_viol++;
      slv_word = (slvq.size() != 0) ? slvq.pop_front() : 8'h00;
      slv_idx  = 0;
      MISO     = slv_word[7];
    end
    if (!p_sclk && SCLK) begin
      n_rise++;
      mosi_bits = {mosi_bits[30:0], MOSI};
    end
    if (p_sclk && !SCLK) begin
      n_fall++;
      slv_idx++;
      if (slv_idx < 8) MISO = slv_word[7 - slv_idx];
    end
    if (bus.rx_wr) begin
      n_rxwr++;
      rxwr_cyc = cyc;
      rxq.push_back(bus.rx_data);
      if (bus.rx_full) n_viol++;
    end
    if (!p_ss && SS_n) n_ss_rise++;
    p_txrd = bus.tx_rd;
    p_sclk = SCLK;
    p_ss   = SS_n;
    aux_track(0, SCLK1, bus1.tx_rd, bus1.rx_wr, bus1.rx_data);
    aux_track(1, SCLK3, bus3.tx_rd, bus3.rx_wr, bus3.rx_data);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    step();
    step();
    while ((busy || busy1 || busy3) && n < 400) begin
      step();
      n++;
    end
    chk(tag, {31'b0, busy | busy1 | busy3}, 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

  initial begin
    logic [7:0] w1, w2, s1, s2;
    PRESETn = 1'b0; enable = 1'b0; MISO = 1'b0;
    bus.tx_data  = '0; bus.tx_empty  = 1'b1; bus.rx_full  = 1'b0; bus.ovf_clr  = 1'b0;
    bus1.tx_data = '0; bus1.tx_empty = 1'b1; bus1.rx_full = 1'b0; bus1.ovf_clr = 1'b0;
    bus3.tx_data = '0; bus3.tx_empty = 1'b1; bus3.rx_full = 1'b0; bus3.ovf_clr = 1'b0;
    for (int k = 0; k < 2; k++) begin a_psclk[k] = 1'b0; a_ptxrd[k] = 1'b0; end
    aux_reset();
    reset_counters();
    n_viol = 0;

    // Reset state
    repeat (3) step();
    chk("rst_sclk",  {31'b0, SCLK},        32'h0);
    chk("rst_ss",    {31'b0, SS_n},        32'h1);
    chk("rst_mosi",  {31'b0, MOSI},        32'h0);
    chk("rst_txrd",  {31'b0, bus.tx_rd},   32'h0);
    chk("rst_rxwr",  {31'b0, bus.rx_wr},   32'h0);
    chk("rst_rxd",   {24'b0, bus.rx_data}, 32'h0);
    chk("rst_ovf",   {31'b0, bus.rx_ovf},  32'h0);
    chk("rst_busy",  {31'b0, busy},        32'h0);

    PRESETn = 1'b1;
    enable  = 1'b1;
    repeat (4) step();
    chk("idle_nopop", n_txrd, 32'd0);

    // Single frame 0xA5 against a slave returning 0x3C
    reset_counters();
    push(8'hA5, 8'h3C);
    wait_idle("a5_idle");
    chk("a5_mosi",  {24'b0, mosi_bits[7:0]}, 32'hA5);
    chk("a5_rx",    {24'b0, rx_at(0)},       32'h3C);
    chk("a5_lat",   rxwr_cyc - txrd_cyc,     32'd33);
    chk("a5_npop",  n_txrd,                  32'd1);
    chk("a5_npush", n_rxwr,                  32'd1);
    chk("a5_nrise", n_rise,                  32'd8);
    chk("a5_ss",    {31'b0, SS_n},           32'h1);

    // Back-to-back frames keep SS_n low between them
    reset_counters();
    s1 = 8'($urandom); s2 = 8'($urandom);
    push(8'h81, s1);
    push(8'h7E, s2);
    wait_idle("b2b_idle");
    chk("b2b_npop",  n_txrd,                   32'd2);
    chk("b2b_npush", n_rxwr,                   32'd2);
    chk("b2b_ssrise", n_ss_rise,               32'd1);
    chk("b2b_mosi",  {16'b0, mosi_bits[15:0]}, 32'h817E);
    chk("b2b_rx0",   {24'b0, rx_at(0)},        {24'b0, s1});
    chk("b2b_rx1",   {24'b0, rx_at(1)},        {24'b0, s2});

    // Overflow: dropped frame, sticky flag, clear, set-wins
    reset_counters();
    bus.rx_full = 1'b1;
    w1 = 8'($urandom); s1 = 8'($urandom);
    push(w1, s1);
    wait_idle("ovf_idle");
    chk("ovf_nowr", n_rxwr,                 32'd0);
    chk("ovf_set",  {31'b0, bus.rx_ovf},    32'h1);
    chk("ovf_data", {24'b0, bus.rx_data},   {24'b0, s1});
    bus.ovf_clr = 1'b1;
    step();
    bus.ovf_clr = 1'b0;
    step();
    chk("ovf_clr", {31'b0, bus.rx_ovf}, 32'h0);

    reset_counters();
    w1 = 8'($urandom); s1 = 8'($urandom);
    push(w1, s1);
    for (int i = 0; i < 20 && n_txrd == 0; i++) step();
    chk("ovf2_load", n_txrd, 32'd1);
    for (int i = 0; i < 60 && cyc < txrd_cyc + 32; i++) step();
    bus.ovf_clr = 1'b1;
    step();
    step();
    chk("ovf_setwins", {31'b0, bus.rx_ovf}, 32'h1);
    bus.ovf_clr = 1'b0;
    wait_idle("ovf2_idle");
    bus.rx_full = 1'b0;

    // Random single frames
    for (int i = 0; i < 6; i++) begin
      reset_counters();
      w1 = 8'($urandom); s1 = 8'($urandom);
      push(w1, s1);
      wait_idle("rnd_idle");
      chk("rnd_mosi", {24'b0, mosi_bits[7:0]}, {24'b0, w1});
      chk("rnd_rx",   {24'b0, rx_at(0)},       {24'b0, s1});
      chk("rnd_lat",  rxwr_cyc - txrd_cyc,     32'd33);
    end

    // enable dropped mid-frame: frame completes, second word stays queued
    reset_counters();
    w1 = 8'($urandom); s1 = 8'($urandom);
    w2 = 8'($urandom); s2 = 8'($urandom);
    push(w1, s1);
    push(w2, s2);
    for (int i = 0; i < 200 && n_fall < 3; i++) step();
    chk("en_bit3", n_fall, 32'd3);
    enable = 1'b0;
    wait_idle("en_idle");
    chk("en_npop",  n_txrd,             32'd1);
    chk("en_npush", n_rxwr,             32'd1);
    chk("en_ss",    {31'b0, SS_n},      32'h1);
    chk("en_left",  txq.size(),         32'd1);
    chk("en_rx",    {24'b0, rx_at(0)},  {24'b0, s1});
    enable = 1'b1;
    wait_idle("en2_idle");
    chk("en2_npop", n_txrd,             32'd2);
    chk("en2_rx",   {24'b0, rx_at(1)},  {24'b0, s2});

    // Reset mid-frame at bit 5
    reset_counters();
    w1 = 8'($urandom); s1 = 8'($urandom);
    push(w1, s1);
    for (int i = 0; i < 200 && n_fall < 5; i++) step();
    chk("mr_bit5", n_fall, 32'd5);
    step();
    step();
    chk("mr_sclk_hi", {31'b0, SCLK}, 32'h1);
    PRESETn = 1'b0;
    #1;
    chk("mr_sclk", {31'b0, SCLK},        32'h0);
    chk("mr_ss",   {31'b0, SS_n},        32'h1);
    chk("mr_busy", {31'b0, busy},        32'h0);
    chk("mr_rxd",  {24'b0, bus.rx_data}, 32'h0);
    repeat (3) step();
    PRESETn = 1'b1;
    repeat (5) step();
    chk("mr_nowr",  n_rxwr,     32'd0);
    chk("mr_npop",  n_txrd,     32'd1);
    chk("mr_busy2", {31'b0, busy}, 32'h0);
    reset_counters();
    s1 = 8'($urandom);
    push(8'h55, s1);
    wait_idle("r55_idle");
    chk("r55_mosi", {24'b0, mosi_bits[7:0]}, 32'h55);
    chk("r55_rx",   {24'b0, rx_at(0)},       {24'b0, s1});
    chk("r55_lat",  rxwr_cyc - txrd_cyc,     32'd33);

    // CLK_DIV=1 and CLK_DIV=3 loopback
    aux_reset();
    w1 = 8'($urandom); w2 = 8'($urandom);
    bus1.tx_data = w1; bus1.tx_empty = 1'b0;
    bus3.tx_data = w2; bus3.tx_empty = 1'b0;
    wait_idle("cd_idle");
    chk("cd1_rx",  {24'b0, a_rx[0]}, {24'b0, w1});
    chk("cd1_min", a_ivmin[0],       32'd1);
    chk("cd1_max", a_ivmax[0],       32'd1);
    chk("cd1_tog", a_ntog[0],        32'd16);
    chk("cd1_nwr", a_nwr[0],         32'd1);
    chk("cd3_rx",  {24'b0, a_rx[1]}, {24'b0, w2});
    chk("cd3_min", a_ivmin[1],       32'd3);
    chk("cd3_max", a_ivmax[1],       32'd3);
    chk("cd3_tog", a_ntog[1],        32'd16);
    chk("cd3_nwr", a_nwr[1],         32'd1);

    chk("strobe_viol", n_viol, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spi_shift_engine.md
SPI_SHIFT_ENGINE -- requirements
Module: spi_shift_engine

Interface
REQ-001 SHALL have parameter DWIDTH, default 8, SPI frame and FIFO word width.
REQ-002 SHALL have parameter CLK_DIV, default 2, PCLK cycles per SCLK half-period, legal range >=1.
REQ-003 SHALL have port PCLK, input, 1, the single system clock.
REQ-004 SHALL have port PRESETn, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port enable, input, 1, transfers permitted (control register bit).
REQ-006 SHALL have port tx_data, input, DWIDTH, TX FIFO head word, first-word-fall-through, valid while tx_empty=0.
REQ-007 SHALL have port tx_empty, input, 1, TX FIFO empty.
REQ-008 SHALL have port tx_rd, output, 1, one-cycle TX FIFO pop strobe.
REQ-009 SHALL have port rx_data, output, DWIDTH, received frame.
REQ-010 SHALL have port rx_wr, output, 1, one-cycle RX FIFO push strobe.
REQ-011 SHALL have port rx_full, input, 1, RX FIFO full.
REQ-012 SHALL have port ovf_clr, input, 1, clears rx_ovf.
REQ-013 SHALL have port rx_ovf, output, 1, sticky RX overflow flag.
REQ-014 SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-015 SHALL have ports SCLK (out, 1), MOSI (out, 1), MISO (in, 1), SS_n (out, 1): SPI mode 0, MSB first.

Function
REQ-016 SHALL implement states IDLE, LOAD, SHIFT, DONE.
REQ-017 IDLE -> LOAD when enable=1 and tx_empty=0; otherwise remain in IDLE.
REQ-018 In LOAD (one cycle): tx_rd=1, shift register <= tx_data, half-period counter and bit counter cleared; next state SHIFT.
REQ-019 In SHIFT: SS_n=0, MOSI = shift register MSB; SCLK toggles every CLK_DIV PCLK cycles, starting low.
REQ-020 On each SCLK rising edge, MISO SHALL be sampled into the LSB of the receive register.
REQ-021 On each SCLK falling edge, the transmit shift register SHALL shift left by one and the bit counter SHALL increment; after the DWIDTH-th falling edge, next state is DONE.
REQ-022 SHIFT SHALL last exactly 2*DWIDTH*CLK_DIV cycles; with DWIDTH=8 and CLK_DIV=2, rx_wr asserts 33 cycles after tx_rd.
REQ-023 In DONE (one cycle): rx_data <= receive register; rx_wr=1 if rx_full=0, else rx_wr=0, the frame is dropped and rx_ovf <= 1.
REQ-024 DONE -> LOAD with SS_n held low (back-to-back) if enable=1 and tx_empty=0; otherwise DONE -> IDLE with SS_n=1.
REQ-025 Deassertion of enable during LOAD or SHIFT SHALL NOT abort the frame; the frame completes and no further pop occurs.
REQ-026 tx_rd SHALL never assert while tx_empty=1; rx_wr SHALL never assert while rx_full=1.
REQ-027 When ovf_clr=1 and an overflow occur in the same cycle, set SHALL win (rx_ovf=1).
REQ-028 In IDLE: SCLK=0, SS_n=1, MOSI=0.

Reset
REQ-029 PRESETn=0 SHALL immediately force state=IDLE, SCLK=0, SS_n=1, MOSI=0, tx_rd=0, rx_wr=0, rx_data=0, rx_ovf=0, busy=0, and clear all counters and shift registers.
REQ-030 A reset asserted mid-frame SHALL discard the frame with no rx_wr; after release, the block SHALL return to IDLE and issue no pop until the IDLE->LOAD condition holds.

Structure
REQ-031 The state enum and the default DWIDTH/CLK_DIV constants SHALL reside in shared package spi_pkg.
REQ-032 The SCLK half-period divider SHALL be a sub-module spi_clk_gen (CLK_DIV parameter; run input; rise/fall one-cycle pulses and SCLK output).

Verification
REQ-033 tx_data=0xA5, MISO driven from a slave model returning 0x3C -> MOSI bits 1,0,1,0,0,1,0,1 on successive rising edges; rx_data=0x3C with rx_wr asserted 33 cycles after tx_rd.
REQ-034 Two words 0x81, 0x7E queued -> two frames, SS_n low continuously between them, exactly two tx_rd and two rx_wr pulses.
REQ-035 rx_full=1 at DONE -> no rx_wr, rx_ovf=1; ovf_clr pulse -> rx_ovf=0; ovf_clr coincident with a new overflow -> rx_ovf stays 1.
REQ-036 enable dropped at bit 3 of a frame with 2 words queued -> frame completes, SS_n=1 afterward, second word remains in FIFO (single tx_rd).
REQ-037 PRESETn pulsed low at bit 5 -> SCLK=0 and SS_n=1 immediately, no rx_wr; after release, a new 0x55 frame completes correctly.
REQ-038 CLK_DIV=1 and CLK_DIV=3 -> SCLK half-period of 1 and 3 PCLK cycles respectively, and correct data loopback (MOSI tied to MISO).
